// File: rtl/boa_pmu_bus_if.sv
// Simple zero-wait-state peripheral bus: read strobe, byte write enables, registered read data.
interface boa_pmu_bus_if #(
    parameter int ADDR_W = 12
);
    logic              bus_re;
    logic [3:0]        bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ready;

    modport master (
        output bus_re, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_re, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/boa_pmu_bus.sv
// Power-management peripheral: shutdown/reset command register plus a one-shot watchdog.
// Reads return one cycle after the strobe; bus_ready is tied high, so there is never backpressure.
module boa_pmu_bus #(
    parameter int                ADDR_W = 12,
    parameter logic [ADDR_W-1:0] BASE   = 'h700
) (
    input  logic            clk,
    input  logic            rst,
    boa_pmu_bus_if.slave    bus,
    output logic            pmb_shdn,
    output logic            pmb_rst
);
    localparam logic [31:0] CMD_SHDN = 32'h0000_5AF0;
    localparam logic [31:0] CMD_RST  = 32'h0000_5A5E;

    logic        sel;
    logic [1:0]  idx;
    logic        cmd_wr;
    logic        load_wr;
    logic        expire;
    logic        wdt_en;
    logic [31:0] wdt_load;
    logic [31:0] wdt_cnt;
    logic [31:0] load_next;
    logic [31:0] rd_mux;
    logic        unused_addr_lsb;

    assign sel             = (bus.bus_addr[ADDR_W-1:4] == BASE[ADDR_W-1:4]);
    assign idx             = bus.bus_addr[3:2];
    assign unused_addr_lsb = ^bus.bus_addr[1:0];
    assign bus.bus_ready   = 1'b1;

    assign cmd_wr  = sel && (idx == 2'd0) && (bus.bus_we == 4'hF);
    assign load_wr = sel && (idx == 2'd1) && (bus.bus_we != 4'h0);
    assign expire  = wdt_en && (wdt_cnt == 32'd0);

    always_comb begin
        load_next = wdt_load;
        for (int b = 0; b < 4; b++) begin
            if (bus.bus_we[b]) begin
                load_next[8*b +: 8] = bus.bus_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (idx)
            2'd1:    rd_mux = wdt_load;
            2'd2:    rd_mux = wdt_cnt;
            2'd3:    rd_mux = {29'd0, wdt_en, pmb_rst, pmb_shdn};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bus_rdata <= 32'd0;
            wdt_load      <= 32'd0;
            wdt_cnt       <= 32'd0;
            wdt_en        <= 1'b0;
            pmb_shdn      <= 1'b0;
            pmb_rst       <= 1'b0;
        end else begin
            // Unselected cycles drive zero so several peripherals can be OR-merged.
            bus.bus_rdata <= (bus.bus_re && sel) ? rd_mux : 32'd0;

            // A reload beats both the decrement and an expiry landing in the same cycle.
            if (load_wr) begin
                wdt_load <= load_next;
                wdt_cnt  <= load_next;
                wdt_en   <= (load_next != 32'd0);
            end else if (expire) begin
                wdt_en   <= 1'b0;
            end else if (wdt_en) begin
                wdt_cnt  <= wdt_cnt - 32'd1;
            end

            if (cmd_wr && (bus.bus_wdata == CMD_SHDN)) begin
                pmb_shdn <= 1'b1;
            end
            if ((cmd_wr && (bus.bus_wdata == CMD_RST)) || (expire && !load_wr)) begin
                pmb_rst <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_boa_pmu_bus.sv
// Directed bench for boa_pmu_bus with a cycle-indexed reference model checked every cycle.
module tb_boa_pmu_bus;
    localparam int                ADDR_W = 12;
    localparam logic [ADDR_W-1:0] BASE   = 12'h700;
    localparam logic [11:0] A_CMD  = 12'h700;
    localparam logic [11:0] A_LOAD = 12'h704;
    localparam logic [11:0] A_CNT  = 12'h708;
    localparam logic [11:0] A_STAT = 12'h70C;

    logic clk = 1'b0;
    logic ext_rst = 1'b1;
    logic loop_en = 1'b0;
    logic rst;
    logic pmb_shdn, pmb_rst;

    assign rst = ext_rst | (loop_en & pmb_rst);

    boa_pmu_bus_if #(.ADDR_W(ADDR_W)) bif ();

    boa_pmu_bus #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif),
        .pmb_shdn (pmb_shdn),
        .pmb_rst  (pmb_rst)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: watchdog described by load value and the cycle it was loaded.
    logic [63:0] cyc        = 64'd0;
    logic [63:0] m_load_cyc = 64'd0;
    logic [31:0] m_load     = 32'd0;
    logic [31:0] m_rdata    = 32'd0;
    logic        m_shdn     = 1'b0;
    logic        m_rst      = 1'b0;
    bit          m_valid    = 1'b0;

    function automatic logic [63:0] m_elapsed();
        return cyc - m_load_cyc;
    endfunction

    function automatic logic [31:0] m_count();
        logic [63:0] el;
        el = m_elapsed();
        return ({32'd0, m_load} > el) ? (m_load - el[31:0]) : 32'd0;
    endfunction

    function automatic logic m_en();
        return (m_load != 32'd0) && (m_elapsed() <= {32'd0, m_load});
    endfunction

    always @(posedge clk) begin
        logic [31:0] rd;
        logic [31:0] nl;
        logic [1:0]  idx;
        bit          sel, lw, exp_now;
        if (rst) begin
            m_shdn     = 1'b0;
            m_rst      = 1'b0;
            m_load     = 32'd0;
            m_rdata    = 32'd0;
            m_load_cyc = cyc + 64'd1;
            m_valid    = 1'b1;
        end else begin
            sel = (bif.bus_addr[11:4] == BASE[11:4]);
            idx = bif.bus_addr[3:2];
            case (idx)
                2'd1:    rd = m_load;
                2'd2:    rd = m_count();
                2'd3:    rd = {29'd0, m_en(), m_rst, m_shdn};
                default: rd = 32'd0;
            endcase
            m_rdata = (bif.bus_re && sel) ? rd : 32'd0;
            exp_now = m_en() && (m_count() == 32'd0);
            lw = sel && (idx == 2'd1) && (bif.bus_we != 4'h0);
            if (lw) begin
                nl = m_load;
                for (int b = 0; b < 4; b++)
                    if (bif.bus_we[b]) nl[8*b +: 8] = bif.bus_wdata[8*b +: 8];
                m_load     = nl;
                m_load_cyc = cyc + 64'd1;
            end else if (exp_now) begin
                m_rst = 1'b1;
            end
            if (sel && (idx == 2'd0) && (bif.bus_we == 4'hF)) begin
                if (bif.bus_wdata == 32'h0000_5AF0) m_shdn = 1'b1;
                if (bif.bus_wdata == 32'h0000_5A5E) m_rst  = 1'b1;
            end
        end
        cyc = cyc + 64'd1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_rdata", bif.bus_rdata, m_rdata);
            check("model_shdn",  32'(pmb_shdn), 32'(m_shdn));
            check("model_rst",   32'(pmb_rst),  32'(m_rst));
            check("ready",       32'(bif.bus_ready), 32'd1);
        end
    end

    task automatic drive(input logic re, input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
        bif.bus_re    = re;
        bif.bus_we    = we;
        bif.bus_addr  = a;
        bif.bus_wdata = d;
        @(negedge clk);
        bif.bus_re = 1'b0;
        bif.bus_we = 4'h0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        drive(1'b0, 4'hF, a, d);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        drive(1'b1, 4'h0, a, 32'd0);
        check(name, bif.bus_rdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        ext_rst = 1'b1;
        idle(2);
        ext_rst = 1'b0;
    endtask

    initial begin
        bif.bus_re = 1'b0; bif.bus_we = 4'h0; bif.bus_addr = 12'h0; bif.bus_wdata = 32'h0;
        idle(3);
        ext_rst = 1'b0;
        check("reset_shdn",  32'(pmb_shdn), 32'd0);
        check("reset_rst",   32'(pmb_rst),  32'd0);
        check("reset_rdata", bif.bus_rdata, 32'd0);
        rd_chk("reset_status", A_STAT, 32'd0);
        rd_chk("reset_load",   A_LOAD, 32'd0);

        // Ignored commands: partial enables, wrong value, wrong block.
        drive(1'b0, 4'b0011, A_CMD, 32'h0000_5AF0);
        check("partial_we_shdn", 32'(pmb_shdn), 32'd0);
        wr(A_CMD, 32'h0000_1234);
        check("bad_val_shdn", 32'(pmb_shdn), 32'd0);
        check("bad_val_rst",  32'(pmb_rst),  32'd0);
        wr(12'h710, 32'h0000_5AF0);
        check("unsel_cmd_shdn", 32'(pmb_shdn), 32'd0);

        // Shutdown command, sticky.
        wr(A_CMD, 32'h0000_5AF0);
        check("shdn_next_cycle", 32'(pmb_shdn), 32'd1);
        idle(3);
        check("shdn_sticky", 32'(pmb_shdn), 32'd1);
        rd_chk("shdn_status", A_STAT, 32'h1);
        do_reset();
        check("shdn_cleared", 32'(pmb_shdn), 32'd0);

        // Byte enables on WDT_LOAD and read timing.
        drive(1'b0, 4'b0101, A_LOAD, 32'hAABB_CCDD);
        rd_chk("load_byte_en", A_LOAD, 32'h00BB_00DD);
        rd_chk("unsel_read", 12'h710, 32'd0);
        bif.bus_re = 1'b1; bif.bus_addr = A_STAT;
        check("rd_same_cycle", bif.bus_rdata, 32'd0);
        @(negedge clk);
        bif.bus_re = 1'b0;
        check("rd_next_cycle", bif.bus_rdata, 32'h4);
        @(negedge clk);
        check("rd_after", bif.bus_rdata, 32'd0);
        wr(A_LOAD, 32'd0);
        rd_chk("disabled_cnt", A_CNT, 32'd0);
        idle(3);
        rd_chk("disabled_cnt_hold", A_CNT, 32'd0);
        rd_chk("disabled_status", A_STAT, 32'd0);

        // Watchdog countdown and expiry.
        wr(A_LOAD, 32'd5);
        bif.bus_re = 1'b1; bif.bus_addr = A_CNT;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("wdt_count", bif.bus_rdata, 32'(5 - i));
            check("wdt_rst_timing", 32'(pmb_rst), (i == 5) ? 32'd1 : 32'd0);
        end
        bif.bus_re = 1'b0;
        rd_chk("wdt_expired_status", A_STAT, 32'h2);
        rd_chk("wdt_load_kept", A_LOAD, 32'd5);
        idle(5);
        check("wdt_rst_sticky", 32'(pmb_rst), 32'd1);
        rd_chk("wdt_no_repeat_cnt", A_CNT, 32'd0);
        do_reset();

        // Periodic kicks keep the watchdog from expiring.
        wr(A_LOAD, 32'd3);
        repeat (6) begin
            idle(1);
            wr(A_LOAD, 32'd3);
        end
        check("kick_no_rst", 32'(pmb_rst), 32'd0);
        rd_chk("kick_status", A_STAT, 32'h4);
        wr(A_LOAD, 32'd0);
        rd_chk("kick_off_cnt", A_CNT, 32'd0);
        idle(6);
        check("kick_off_rst", 32'(pmb_rst), 32'd0);
        rd_chk("kick_off_status", A_STAT, 32'd0);

        // Reload in the expiry cycle wins.
        wr(A_LOAD, 32'd1);
        idle(1);
        wr(A_LOAD, 32'd4);
        check("reload_prio_rst", 32'(pmb_rst), 32'd0);
        rd_chk("reload_prio_cnt", A_CNT, 32'd4);
        wr(A_LOAD, 32'd0);

        // Shutdown write coinciding with expiry sets both.
        wr(A_LOAD, 32'd1);
        idle(1);
        wr(A_CMD, 32'h0000_5AF0);
        check("simul_shdn", 32'(pmb_shdn), 32'd1);
        check("simul_rst",  32'(pmb_rst),  32'd1);
        rd_chk("simul_status", A_STAT, 32'h3);
        do_reset();

        // Reset kills a pending read and blocks writes.
        wr(A_CMD, 32'h0000_5AF0);
        ext_rst = 1'b1;
        drive(1'b1, 4'h0, A_STAT, 32'd0);
        check("rst_pending_rdata", bif.bus_rdata, 32'd0);
        check("rst_clears_shdn", 32'(pmb_shdn), 32'd0);
        wr(A_CMD, 32'h0000_5AF0);
        check("rst_write_ignored", 32'(pmb_shdn), 32'd0);
        ext_rst = 1'b0;
        idle(1);
        check("rst_write_ignored2", 32'(pmb_shdn), 32'd0);

        // pmb_rst looped back into rst gives a single bounded pulse.
        wr(A_LOAD, 32'd9);
        loop_en = 1'b1;
        wr(A_CMD, 32'h0000_5A5E);
        check("loop_rst_high", 32'(pmb_rst), 32'd1);
        check("loop_sys_rst",  32'(rst),     32'd1);
        idle(1);
        check("loop_rst_low",  32'(pmb_rst), 32'd0);
        check("loop_sys_rst_low", 32'(rst),  32'd0);
        rd_chk("loop_load", A_LOAD, 32'd0);
        rd_chk("loop_cnt",  A_CNT,  32'd0);
        rd_chk("loop_stat", A_STAT, 32'd0);
        loop_en = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
